// File: rtl/if_id_pipeline_pkg.sv
// Shared fetch/decode pipeline constants, PC select encoding and address helpers.
package if_id_pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC    = 32'd4;
    localparam logic [XLEN-1:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [XLEN-1:0] BUBBLE_PC = 32'h0000_0000;
    localparam logic [15:0]     STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        PC_SEL_HOLD     = 2'd0,
        PC_SEL_SEQ      = 2'd1,
        PC_SEL_REDIRECT = 2'd2
    } pc_sel_e;

    // Instructions are word aligned; drop the low two address bits.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(32'd3);
    endfunction

endpackage

// File: rtl/if_id_pipeline_pc_register.sv
// Program counter register with next-PC selection: redirect beats advance beats hold.
module pc_register
    import if_id_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc
);

    pc_sel_e           pc_sel_s;
    logic [XLEN-1:0]   pc_next_s;
    logic [XLEN-1:0]   pc_r;

    // Select the source of the next PC.
    always_comb begin
        pc_sel_s = PC_SEL_HOLD;
        if (branch_taken) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (pc_write) begin
            pc_sel_s = PC_SEL_SEQ;
        end else begin
            pc_sel_s = PC_SEL_HOLD;
        end
    end

    // Next-PC mux; the increment wraps naturally modulo 2^32.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEL_REDIRECT: pc_next_s = align_word(branch_target);
            PC_SEL_SEQ:      pc_next_s = pc_r + PC_INC;
            PC_SEL_HOLD:     pc_next_s = pc_r;
            default:         pc_next_s = pc_r;
        endcase
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/if_id_pipeline.sv
// IF/ID pipeline stage: PC register, IF/ID latch with bubble injection, stall counter.
module if_id_pipeline
    import if_id_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        flush,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic [15:0] stall_count
);

    logic [31:0] pc_s;
    logic [31:0] if_id_pc_r;
    logic [31:0] if_id_instr_r;
    logic        if_id_valid_r;
    logic [15:0] stall_count_r;
    logic        squash_s;
    logic        stall_cycle_s;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc_s)
    );

    // A redirect and a flush together still produce only one bubble.
    assign squash_s      = flush | branch_taken;
    assign stall_cycle_s = ~pc_write & ~branch_taken;

    // IF/ID latch: bubble on squash, capture the pre-update PC on write, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr_r <= NOP_INSTR;
            if_id_pc_r    <= BUBBLE_PC;
            if_id_valid_r <= 1'b0;
        end else if (squash_s) begin
            if_id_instr_r <= NOP_INSTR;
            if_id_pc_r    <= BUBBLE_PC;
            if_id_valid_r <= 1'b0;
        end else if (if_id_write) begin
            if_id_instr_r <= instruction;
            if_id_pc_r    <= pc_s;
            if_id_valid_r <= 1'b1;
        end else begin
            if_id_instr_r <= if_id_instr_r;
            if_id_pc_r    <= if_id_pc_r;
            if_id_valid_r <= if_id_valid_r;
        end
    end

    // Saturating count of PC stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_r <= 16'd0;
        end else if (stall_cycle_s && (stall_count_r != STALL_MAX)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign pc                = pc_s;
    assign if_id_pc          = if_id_pc_r;
    assign if_id_instruction = if_id_instr_r;
    assign if_id_valid       = if_id_valid_r;
    assign stall_count       = stall_count_r;

endmodule

// File: doc/if_id_pipeline.md
IF_ID_PIPELINE -- requirements
Module: if_id_pipeline

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble word injected on flush.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port instruction  input  32: word returned by the fetch stage for the current pc (combinational path).
REQ-006 Port pc_write  input  1: PC advance enable from the hazard unit; 0 = stall the PC.
REQ-007 Port if_id_write  input  1: IF/ID latch enable from the hazard unit; 0 = hold the latch.
REQ-008 Port branch_taken  input  1: redirect request resolved downstream.
REQ-009 Port branch_target  input  32: redirect address, valid when branch_taken=1.
REQ-010 Port flush  input  1: squash the IF/ID contents without redirecting.
REQ-011 Port pc  output  32: current fetch address driven to the fetch stage.
REQ-012 Port if_id_pc  output  32: PC of the latched instruction.
REQ-013 Port if_id_instruction  output  32: latched instruction for decode.
REQ-014 Port if_id_valid  output  1: latched instruction is real (not a bubble).
REQ-015 Port stall_count  output  16: saturating count of cycles with pc_write=0 and branch_taken=0.

Function
REQ-016 PC update priority, per cycle: reset, then branch_taken, then pc_write, else hold.
REQ-017 On branch_taken=1, pc SHALL load {branch_target[31:2],2'b00} next cycle regardless of pc_write.
REQ-018 On pc_write=1 with no redirect, pc SHALL load pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 On pc_write=0 with no redirect, pc SHALL hold.
REQ-020 IF/ID update priority: reset, then (flush OR branch_taken), then if_id_write, else hold.
REQ-021 Bubble: if_id_instruction<=NOP_INSTR, if_id_pc<=0, if_id_valid<=0.
REQ-022 Capture (if_id_write=1, no flush/redirect): if_id_instruction<=instruction, if_id_pc<=pc (pre-update value), if_id_valid<=1.
REQ-023 Latency: an instruction fetched at pc in cycle N SHALL appear on IF/ID outputs in cycle N+1.
REQ-024 Simultaneous branch_taken and flush SHALL act as a redirect plus a single bubble (no double effect).
REQ-025 pc_write=1 with if_id_write=0 is legal; the PC advances and the skipped word is not captured.
REQ-026 stall_count SHALL increment by 1 each counted cycle and saturate at 16'hFFFF.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 On reset, the following SHALL take effect on the next edge, overriding all other inputs including mid-redirect: pc=RESET_PC, if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_valid=0, stall_count=0.
REQ-029 In the first cycle after reset deasserts, pc SHALL equal RESET_PC and the first capture SHALL record if_id_pc=RESET_PC.

Structure
REQ-030 NOP_INSTR value, the 32-bit XLEN width constant and the PC increment (4) SHALL live in the shared pipeline package, alongside the other stage constants.
REQ-031 A single sub-module pc_register (PC state plus next-PC mux, REQ-016..019) SHALL be instantiated; the IF/ID latch and the counter stay in the top module.

Verification
REQ-032 Reset, then 3 cycles with pc_write=1 and if_id_write=1 -> pc sequence 0,4,8,12; if_id_pc lags by one cycle; if_id_valid=1 from the first capture.
REQ-033 pc=8, pc_write=0 and if_id_write=0 for 2 cycles -> pc holds at 8, IF/ID holds, stall_count rises by 2.
REQ-034 pc=12, branch_taken=1, branch_target=32'h0000_0043, pc_write=0 -> next pc=32'h40; IF/ID holds a bubble (0x13, valid=0).
REQ-035 flush=1 and branch_taken=1 in the same cycle, target 0x100 -> pc=0x100; exactly one bubble; next cycle captures if_id_pc=0x100.
REQ-036 pc forced to 32'hFFFF_FFFC via redirect, then pc_write=1 -> pc=0; reset asserted during a redirect -> pc=RESET_PC.
REQ-037 Hold pc_write=0 for 70000 cycles -> stall_count saturates at 16'hFFFF.
